// File: rtl/sprite_layer_renderer_if.sv
// sprite_layer_renderer_if
// Memory-side bus of the sprite layer renderer: the shared sprite ROM
// (registered, one cycle read latency) and the shared combinational palette.
// The renderer owns the master modport; the ROM/palette side uses slave.
interface sprite_layer_renderer_if #(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 7
);
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_address,
    output pal_index,
    input  rom_q,
    input  pal_red,
    input  pal_green,
    input  pal_blue
  );

  modport slave (
    input  rom_address,
    input  pal_index,
    output rom_q,
    output pal_red,
    output pal_green,
    output pal_blue
  );
endinterface

// File: rtl/sprite_layer_renderer.sv
// sprite_layer_renderer
// Pipelined multi-sprite pixel generator for the VGA path. For each scan
// position the lowest-index enabled sprite whose box covers the pixel wins;
// its current animation frame is fetched from the shared sprite ROM and the
// ROM index is looked up in the shared palette. Transparent indices show the
// background colour. Latency from DrawX/DrawY/blank to red/green/blue is 3.
//
// Optional build macro SPRITE_COLLISION_EN adds a sticky 'collision' output
// that is set when two or more slots cover a visible pixel and cleared by
// frame_start (a set in the same cycle wins over the clear).
module sprite_layer_renderer #(
  parameter int NUM_SPRITES     = 4,
  parameter int SPRITE_W        = 16,
  parameter int SPRITE_H        = 16,
  parameter int NUM_FRAMES      = 4,
  parameter int FRAME_TICKS     = 8,
  parameter int IDX_W           = 7,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ADDR_W          = 13,
  localparam int ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  input  logic                     blank,
  input  logic                     frame_start,
  input  logic [10*NUM_SPRITES-1:0] sprite_x,
  input  logic [10*NUM_SPRITES-1:0] sprite_y,
  input  logic [NUM_SPRITES-1:0]   sprite_en,
  input  logic [3:0]               bg_red,
  input  logic [3:0]               bg_green,
  input  logic [3:0]               bg_blue,
  sprite_layer_renderer_if.master  mem,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     sprite_hit,
  output logic [ID_W-1:0]          sprite_id
`ifdef SPRITE_COLLISION_EN
  ,
  output logic                     collision
`endif
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  // Box limits widened by one bit so the unsigned compare against the
  // 10-bit wrapped offsets is exact for any sprite size up to 1024.
  localparam logic [10:0] SPRITE_W_LIM = 11'(SPRITE_W);
  localparam logic [10:0] SPRITE_H_LIM = 11'(SPRITE_H);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [TICK_W-1:0]  LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [IDX_W-1:0]   CLEAR_IDX  = IDX_W'(TRANSPARENT_IDX);

  // ---------------------------------------------------------------------
  // Animation state
  // ---------------------------------------------------------------------
  logic [FRAME_W-1:0] frame;
  logic [TICK_W-1:0]  tick_cnt;

  // ---------------------------------------------------------------------
  // Stage 0: combinational hit test and address generation
  // ---------------------------------------------------------------------
  logic [9:0]             dx [NUM_SPRITES];
  logic [9:0]             dy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] in_box;

  logic                   win_hit;
  logic [ID_W-1:0]        win_id;
  logic [9:0]             win_dx;
  logic [9:0]             win_dy;
  logic [ADDR_W-1:0]      rom_addr_next;

  // ---------------------------------------------------------------------
  // Stage 1 and stage 2 pipeline registers
  // ---------------------------------------------------------------------
  logic                   valid_s1;
  logic                   hit_s1;
  logic [ID_W-1:0]        id_s1;
  logic                   blank_s1;

  logic                   valid_s2;
  logic                   hit_s2;
  logic [ID_W-1:0]        id_s2;
  logic                   blank_s2;

  // Per-slot offsets use 10-bit wrap arithmetic, so a sprite hanging off the
  // left or top edge wraps to huge offsets and is simply not in its box there.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i]     = DrawX - sprite_x[10*i +: 10];
      dy[i]     = DrawY - sprite_y[10*i +: 10];
      in_box[i] = sprite_en[i]
                  && ({1'b0, dx[i]} < SPRITE_W_LIM)
                  && ({1'b0, dy[i]} < SPRITE_H_LIM);
    end
  end

  // Priority pick: scanning from the highest index down lets the lowest
  // in-box slot overwrite the others. Transparency plays no part here, so a
  // clear pixel of the winner never reveals a lower-priority sprite.
  always_comb begin
    win_hit = 1'b0;
    win_id  = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (in_box[i]) begin
        win_hit = 1'b1;
        win_id  = ID_W'(i);
        win_dx  = dx[i];
        win_dy  = dy[i];
      end
    end
  end

  // ROM layout is sprite-major, then frame, then row, then column; the
  // product is formed in 32 bits and truncated to the ROM address width.
  assign rom_addr_next = ADDR_W'(
    ((32'(win_id) * 32'(NUM_FRAMES) + 32'(frame)) * 32'(SPRITE_H)
     + 32'(win_dy)) * 32'(SPRITE_W) + 32'(win_dx));

`ifdef SPRITE_COLLISION_EN
  logic multi_hit;
  logic seen_hit;
  logic coll_s1;
  logic coll_s2;

  // Overlap detector: true once a second in-box slot is found at this pixel.
  always_comb begin
    multi_hit = 1'b0;
    seen_hit  = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (in_box[i]) begin
        if (seen_hit) begin
          multi_hit = 1'b1;
        end
        seen_hit = 1'b1;
      end
    end
  end
`endif

  // Animation: count frame_start pulses and step the frame every FRAME_TICKS.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame    <= '0;
      tick_cnt <= '0;
    end else if (frame_start) begin
      if (tick_cnt == LAST_TICK) begin
        tick_cnt <= '0;
        frame    <= (frame == LAST_FRAME) ? '0 : frame + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Stage 1: launch the ROM read and carry the pixel's hit/id/blank along.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      mem.rom_address <= '0;
      valid_s1        <= 1'b0;
      hit_s1          <= 1'b0;
      id_s1           <= '0;
      blank_s1        <= 1'b0;
    end else begin
      mem.rom_address <= rom_addr_next;
      valid_s1        <= 1'b1;
      hit_s1          <= win_hit;
      id_s1           <= win_id;
      blank_s1        <= blank;
    end
  end

  // Stage 2: wait out the ROM latency so the side-band lines up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      valid_s2 <= 1'b0;
      hit_s2   <= 1'b0;
      id_s2    <= '0;
      blank_s2 <= 1'b0;
    end else begin
      valid_s2 <= valid_s1;
      hit_s2   <= hit_s1;
      id_s2    <= id_s1;
      blank_s2 <= blank_s1;
    end
  end

  // The ROM word feeds the palette directly; its colour is ready this cycle.
  assign mem.pal_index = mem.rom_q;

  // Output stage: black outside the visible region or while the pipeline is
  // refilling after reset, palette colour for opaque sprite pixels, else the
  // background. sprite_id names the slot only when it was actually drawn.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      sprite_hit <= 1'b0;
      sprite_id  <= '0;
    end else if (valid_s2 && blank_s2) begin
      if (hit_s2 && (mem.rom_q != CLEAR_IDX)) begin
        red        <= mem.pal_red;
        green      <= mem.pal_green;
        blue       <= mem.pal_blue;
        sprite_hit <= 1'b1;
        sprite_id  <= id_s2;
      end else begin
        red        <= bg_red;
        green      <= bg_green;
        blue       <= bg_blue;
        sprite_hit <= 1'b0;
        sprite_id  <= '0;
      end
    end else begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      sprite_hit <= 1'b0;
      sprite_id  <= '0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  // Overlap flags ride the same pipeline so the set lands with the pixel.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      coll_s1 <= 1'b0;
      coll_s2 <= 1'b0;
    end else begin
      coll_s1 <= multi_hit && blank;
      coll_s2 <= coll_s1;
    end
  end

  // Sticky collision flag: a set beats a frame_start clear in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      collision <= 1'b0;
    end else if (valid_s2 && coll_s2) begin
      collision <= 1'b1;
    end else if (frame_start) begin
      collision <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_layer_renderer.sv
// tb_sprite_layer_renderer
// Self-checking bench for sprite_layer_renderer. A behavioural model computes
// every pixel straight from the box/priority/address/colour rules and a
// compare process checks the DUT against it on every cycle; a few directed
// pixels with hand-worked values pin the model. Build with SPRITE_COLLISION_EN
// defined to also exercise the collision output.
`timescale 1ns/1ps
module tb_sprite_layer_renderer;

  localparam int NS     = 4;
  localparam int W      = 16;
  localparam int H      = 16;
  localparam int NF     = 4;
  localparam int FT     = 8;
  localparam int IDX_W  = 7;
  localparam int ADDR_W = 13;
  localparam int ROM_N  = 1 << ADDR_W;

  logic             vga_clk = 1'b0;
  logic             reset;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic             blank;
  logic             frame_start;
  logic [10*NS-1:0] sprite_x;
  logic [10*NS-1:0] sprite_y;
  logic [NS-1:0]    sprite_en;
  logic [3:0]       bg_red;
  logic [3:0]       bg_green;
  logic [3:0]       bg_blue;
  logic [3:0]       red;
  logic [3:0]       green;
  logic [3:0]       blue;
  logic             sprite_hit;
  logic [1:0]       sprite_id;
`ifdef SPRITE_COLLISION_EN
  logic             collision;
`endif

  int total = 0;
  int bad   = 0;

  sprite_layer_renderer_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) mem ();

  sprite_layer_renderer #(
    .NUM_SPRITES(NS), .SPRITE_W(W), .SPRITE_H(H), .NUM_FRAMES(NF),
    .FRAME_TICKS(FT), .IDX_W(IDX_W), .TRANSPARENT_IDX(0), .ADDR_W(ADDR_W)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .frame_start(frame_start),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .sprite_en  (sprite_en),
    .bg_red     (bg_red),
    .bg_green   (bg_green),
    .bg_blue    (bg_blue),
    .mem        (mem.master),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .sprite_hit (sprite_hit),
    .sprite_id  (sprite_id)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision  (collision)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  // Sprite ROM with one cycle of read latency, and a simple palette.
  logic [6:0] rom_mem [ROM_N];

  always @(posedge vga_clk) mem.rom_q <= rom_mem[mem.rom_address];

  assign mem.pal_red   = mem.pal_index[3:0];
  assign mem.pal_green = mem.pal_index[6:3];
  assign mem.pal_blue  = ~mem.pal_index[3:0];

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hit;
    logic [1:0] id;
    logic       multi;
  } px_t;

  px_t         s1, s2, eo;
  logic [12:0] e_addr;
  bit          e_addr_v;
  bit          e_coll;
  int          m_frame;
  int          m_tick;
  bit          model_ready = 0;

  function automatic logic [31:0] pack_px(px_t p);
    return {17'd0, p.r, p.g, p.b, p.hit, p.id};
  endfunction

  function automatic logic [31:0] lit(logic [3:0] r, logic [3:0] g, logic [3:0] b,
                                     logic h, logic [1:0] id);
    return {17'd0, r, g, b, h, id};
  endfunction

  function automatic logic [31:0] dut_px();
    return {17'd0, red, green, blue, sprite_hit, sprite_id};
  endfunction

  // Compute what the current input pixel must produce, straight from the rules.
  function automatic void eval_pixel(output px_t p, output logic [12:0] addr, output bit hit);
    int win, cnt, dx, dy, wdx, wdy, a;
    logic [6:0] idx;
    win = -1; cnt = 0; wdx = 0; wdy = 0;
    for (int i = 0; i < NS; i++) begin
      dx = (int'(DrawX) - int'(sprite_x[10*i +: 10]) + 1024) % 1024;
      dy = (int'(DrawY) - int'(sprite_y[10*i +: 10]) + 1024) % 1024;
      if (sprite_en[i] && dx < W && dy < H) begin
        cnt++;
        if (win < 0) begin
          win = i; wdx = dx; wdy = dy;
        end
      end
    end
    hit  = (win >= 0);
    a    = ((((hit ? win : 0) * NF + m_frame) * H + wdy) * W + wdx) % ROM_N;
    addr = 13'(a);
    idx  = rom_mem[addr];
    p    = '0;
    if (blank) begin
      if (hit && idx != 7'd0) begin
        p.r = idx[3:0]; p.g = idx[6:3]; p.b = ~idx[3:0];
        p.hit = 1'b1; p.id = 2'(win);
      end else begin
        p.r = bg_red; p.g = bg_green; p.b = bg_blue;
      end
    end
    p.multi = blank && (cnt >= 2);
  endfunction

  // Model advances on each rising edge using the inputs held since the last falling edge.
  always @(posedge vga_clk) begin
    px_t cur;
    logic [12:0] a;
    bit h;
    if (reset) begin
      s1 = '0; s2 = '0; eo = '0;
      e_addr = '0; e_addr_v = 1;
      e_coll = 0; m_frame = 0; m_tick = 0;
      model_ready = 1;
    end else begin
      eval_pixel(cur, a, h);
      eo = s2; s2 = s1; s1 = cur;
      e_addr = a; e_addr_v = h;
      if (eo.multi) e_coll = 1;
      else if (frame_start) e_coll = 0;
      if (frame_start) begin
        if (m_tick == FT - 1) begin
          m_tick = 0;
          m_frame = (m_frame + 1) % NF;
        end else begin
          m_tick++;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge vga_clk) begin
    if (model_ready) begin
      check_output("model_pixel", dut_px(), pack_px(eo));
      if (e_addr_v) check_output("model_addr", 32'(mem.rom_address), 32'(e_addr));
`ifdef SPRITE_COLLISION_EN
      check_output("model_collision", 32'(collision), 32'(e_coll));
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (called right after a falling edge)
  // ---------------------------------------------------------------------
  task automatic apply_stimulus(input int x, input int y, input bit bl);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
  endtask

  task automatic set_sprite(input int i, input int x, input int y, input bit en);
    sprite_x[10*i +: 10] = 10'(x);
    sprite_y[10*i +: 10] = 10'(y);
    sprite_en[i]         = en;
  endtask

  // Drive one pixel and hold it; check the address one cycle on, colour three on.
  task automatic expect_pixel(input string name, input int x, input int y, input bit bl,
                              input bit chk_addr, input logic [31:0] exp_addr,
                              input logic [31:0] exp_px);
    apply_stimulus(x, y, bl);
    @(negedge vga_clk);
    if (chk_addr) check_output({name, "_addr"}, 32'(mem.rom_address), exp_addr);
    @(negedge vga_clk);
    @(negedge vga_clk);
    check_output({name, "_px"}, dut_px(), exp_px);
  endtask

  task automatic pulse_frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
    end
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    int k;
    reset = 1'b1; frame_start = 1'b0;
    DrawX = '0; DrawY = '0; blank = 1'b0;
    sprite_x = '0; sprite_y = '0; sprite_en = '0;
    bg_red = 4'h3; bg_green = 4'h6; bg_blue = 4'h9;
    for (int a = 0; a < ROM_N; a++) begin
      rom_mem[a] = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
    end
    rom_mem[0]    = 7'h11;
    rom_mem[1]    = 7'h00;
    rom_mem[83]   = 7'h05;
    rom_mem[255]  = 7'h2A;
    rom_mem[256]  = 7'h47;
    rom_mem[1107] = 7'h33;

    repeat (3) @(negedge vga_clk);
    check_output("reset_pixel", dut_px(), 32'd0);
    check_output("reset_addr", 32'(mem.rom_address), 32'd0);

    set_sprite(0, 100, 50, 1'b1);
    reset = 1'b0;
    expect_pixel("origin", 100, 50, 1'b1, 1'b1, 32'd0, lit(4'h1, 4'h2, 4'hE, 1'b1, 2'd0));
    expect_pixel("corner", 115, 65, 1'b1, 1'b1, 32'd255, lit(4'hA, 4'h5, 4'h5, 1'b1, 2'd0));
    expect_pixel("outside", 116, 50, 1'b1, 1'b0, 32'd0, lit(4'h3, 4'h6, 4'h9, 1'b0, 2'd0));
    expect_pixel("transparent", 101, 50, 1'b1, 1'b1, 32'd1, lit(4'h3, 4'h6, 4'h9, 1'b0, 2'd0));
    expect_pixel("blanked", 100, 50, 1'b0, 1'b0, 32'd0, lit(4'h0, 4'h0, 4'h0, 1'b0, 2'd0));

    set_sprite(0, 200, 100, 1'b1);
    set_sprite(1, 200, 100, 1'b1);
    expect_pixel("prio_slot0", 203, 105, 1'b1, 1'b1, 32'd83, lit(4'h5, 4'h0, 4'hA, 1'b1, 2'd0));
    set_sprite(0, 200, 100, 1'b0);
    expect_pixel("prio_slot1", 203, 105, 1'b1, 1'b1, 32'd1107, lit(4'h3, 4'h6, 4'hC, 1'b1, 2'd1));

    set_sprite(0, 100, 50, 1'b1);
    set_sprite(1, 0, 0, 1'b0);
    pulse_frames(8);
    expect_pixel("frame1", 100, 50, 1'b1, 1'b1, 32'd256, lit(4'h7, 4'h8, 4'h8, 1'b1, 2'd0));
    pulse_frames(24);
    expect_pixel("frame_wrap", 100, 50, 1'b1, 1'b1, 32'd0, lit(4'h1, 4'h2, 4'hE, 1'b1, 2'd0));

`ifdef SPRITE_COLLISION_EN
    set_sprite(2, 100, 50, 1'b1);
    expect_pixel("overlap", 100, 50, 1'b1, 1'b1, 32'd0, lit(4'h1, 4'h2, 4'hE, 1'b1, 2'd0));
    check_output("collision_set", 32'(collision), 32'd1);
    apply_stimulus(500, 400, 1'b1);
    repeat (4) @(negedge vga_clk);
    check_output("collision_held", 32'(collision), 32'd1);
    pulse_frames(1);
    check_output("collision_clear", 32'(collision), 32'd0);
    set_sprite(2, 0, 0, 1'b0);
`endif

    pulse_frames(8);
    expect_pixel("pre_reset", 100, 50, 1'b1, 1'b1, 32'd256, lit(4'h7, 4'h8, 4'h8, 1'b1, 2'd0));
    reset = 1'b1;
    @(negedge vga_clk);
    check_output("midreset_pixel", dut_px(), 32'd0);
    check_output("midreset_addr", 32'(mem.rom_address), 32'd0);
    reset = 1'b0;
    @(negedge vga_clk);
    check_output("post_reset_frame0_addr", 32'(mem.rom_address), 32'd0);
    check_output("post_reset_black1", dut_px(), 32'd0);
    @(negedge vga_clk);
    check_output("post_reset_black2", dut_px(), 32'd0);
    @(negedge vga_clk);
    check_output("post_reset_pixel", dut_px(), lit(4'h1, 4'h2, 4'hE, 1'b1, 2'd0));

    // Randomised phase: sprites clustered so overlaps and edges are common.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) begin
        for (int i = 0; i < NS; i++) begin
          if ($urandom_range(0, 9) == 0)
            set_sprite(i, $urandom_range(1010, 1023), $urandom_range(1010, 1023), 1'($urandom_range(0, 1)));
          else
            set_sprite(i, 300 + $urandom_range(0, 30), 200 + $urandom_range(0, 30),
                       $urandom_range(0, 3) != 0);
        end
      end
      k = $urandom_range(0, NS - 1);
      apply_stimulus(int'(sprite_x[10*k +: 10]) + $urandom_range(0, 23) - 4,
                     int'(sprite_y[10*k +: 10]) + $urandom_range(0, 23) - 4,
                     $urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 499) == 0);
      @(negedge vga_clk);
    end
    reset = 1'b0;
    frame_start = 1'b0;
    repeat (4) @(negedge vga_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_layer_renderer.md
Name: sprite_layer_renderer

Overview:
- Pipelined multi-sprite pixel generator for the VGA path. Draws NUM_SPRITES independently positioned, animated sprites from one shared sprite ROM and one shared palette.
- For each scan position it selects the highest-priority sprite whose box covers the pixel, then fetches that sprite's current animation frame.
- Transparent palette indices show the background colour.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour output mux. It succeeds the single-sprite renderer.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; slot 0 has the highest priority.
- SPRITE_W, 16, sprite width in pixels (power of two).
- SPRITE_H, 16, sprite height in pixels.
- NUM_FRAMES, 4, animation frames per sprite.
- FRAME_TICKS, 8, frame_start pulses per animation step (≥1).
- IDX_W, 7, palette index width.
- TRANSPARENT_IDX, 0, palette index treated as see-through.
- ADDR_W, 13, ROM address width; must be ≥ clog2(NUM_SPRITES*NUM_FRAMES*SPRITE_W*SPRITE_H).

Ports:
- vga_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = visible region
- frame_start  in  1  one-cycle pulse per video frame
- sprite_x  in  10*NUM_SPRITES  top-left X per slot; slot i at bits [10i+9:10i]
- sprite_y  in  10*NUM_SPRITES  top-left Y per slot
- sprite_en  in  NUM_SPRITES  slot enables
- bg_red / bg_green / bg_blue  in  4 each  background colour
- rom_address  out  ADDR_W  sprite ROM address; ROM has 1-cycle read latency
- rom_q  in  IDX_W  ROM data
- pal_index  out  IDX_W  palette lookup index (palette is combinational)
- pal_red / pal_green / pal_blue  in  4 each  palette colour
- red / green / blue  out  4 each  registered pixel colour
- sprite_hit  out  1  registered: opaque sprite pixel drawn
- sprite_id  out  clog2(NUM_SPRITES) (min 1)  registered: slot drawn

Behaviour:
- Reset: red/green/blue=0, sprite_hit=0, sprite_id=0, rom_address=0, anim frame=0, tick counter=0, all pipeline valid bits=0.
- Hit test, per slot i (10-bit wrap arithmetic):
  - dx = DrawX - sprite_x[i], dy = DrawY - sprite_y[i].
  - Slot is in-box when sprite_en[i] && dx < SPRITE_W && dy < SPRITE_H.
  - A sprite partly off-screen left or top wraps and is not drawn there.
- Selection: the lowest-index in-box slot wins, decided from the box test only. A transparent winning pixel does not reveal lower-priority sprites.
- Address: ((id*NUM_FRAMES + frame)*SPRITE_H + dy)*SPRITE_W + dx, truncated to ADDR_W.
- Pipeline: 3-cycle latency. For inputs sampled at cycle N:
  - N+1: rom_address, hit, id and blank are registered.
  - N+2: rom_q is valid and drives pal_index.
  - N+3: red/green/blue/sprite_hit/sprite_id update.
- Colour at N+3:
  - blank=0 (delayed copy) → 0,0,0 and hit=0.
  - Otherwise, if hit and rom_q≠TRANSPARENT_IDX → palette colour, sprite_hit=1.
  - Otherwise → bg colour, sprite_hit=0.
  - sprite_id holds the winning slot when hit, else 0.
- Animation:
  - The tick counter increments on frame_start.
  - When the counter reaches FRAME_TICKS-1 and another frame_start arrives, it clears and frame advances.
  - frame wraps NUM_FRAMES-1 → 0.
  - frame is sampled together with DrawX at cycle N, so a frame change mid-line takes effect on the next sampled pixel.
- sprite_x/sprite_y/sprite_en are sampled every cycle. Software updates them during vertical blank.
- reset mid-line: pipeline is flushed and outputs are black for 3 cycles after reset deasserts.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Enabled:
  - Adds output collision (1 bit, registered, sticky).
  - Set when two or more slots are in-box at a pixel with blank=1. Set is aligned to the N+3 output timing.
  - Cleared on frame_start. If set and clear occur in the same cycle, set wins.
  - Reset value 0.
- Disabled: the port and its logic are absent.

Test Plan:
- Slot 0 enabled at (100,50), ROM pattern = address LSBs (non-zero), DrawX=100, DrawY=50, blank=1 → rom_address=0 at N+1; red/green/blue = palette(rom_q) at N+3; sprite_hit=1, sprite_id=0.
- Slots 0 and 1 both at (200,100), both enabled → winning id=0, address uses id 0. Disable slot 0 → id=1, address base = 1*NUM_FRAMES*256 = 1024.
- Pixel (115,65) inside, (116,50) outside for sprite at (100,50) → hit, then bg colour with sprite_hit=0. rom_q=TRANSPARENT_IDX inside the box → bg colour, sprite_hit=0.
- 8 frame_start pulses → frame=1, address offset +256. 32 pulses → frame wraps to 0.
- blank=0 with a sprite in-box → output 0,0,0 and sprite_hit=0 at N+3. Reset asserted mid-stream → all outputs 0 and frame=0 on the next cycle.
- With SPRITE_COLLISION_EN, overlapping slots 0 and 2 → collision=1 at N+3, held until frame_start, then 0.
